// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   - Load-use stall: freezes PC and IF/ID and injects one ID/EX bubble for
//     each stalled cycle.
//   - Taken-branch flush: squashes IF/ID and ID/EX. A taken branch overrides
//     any stall in the same cycle.
//   - EX operand forwarding from EX/MEM (preferred) or MEM/WB. Register $zero
//     is never forwarded.
//   - Mul/div scheduling: a two-state FSM tracks the HI/LO busy window. While
//     the unit is busy, mfhi/mflo and a further mul/div are held in ID.
//   - Saturating performance counters for stall cycles and branch flushes.
//
// Ports
//   clk, reset_n            clock; synchronous active-low reset
//   id_rs/id_rt             source registers of the ID instruction
//   id_uses_rs/id_uses_rt   the ID instruction really reads rs / rt
//   id_reads_hilo           the ID instruction is mfhi/mflo
//   id_is_muldiv            the ID instruction is mult/multu/div/divu
//   ex_rs/ex_rt             source registers of the EX instruction
//   ex_mem_read, ex_rd      the EX instruction is a load, and its destination
//   mem_reg_write, mem_rd   register write-back info of the MEM stage
//   wb_reg_write, wb_rd     register write-back info of the WB stage
//   branch_taken_ex         branch/jump resolved taken in EX
//   muldiv_start_ex         a mul/div instruction is in EX this cycle
//   pc_write, ifid_write    PC / IF-ID load enables
//   ifid_flush, idex_flush  load a NOP into IF/ID / a bubble into ID/EX
//   fwd_a, fwd_b            00 regfile, 10 EX/MEM, 01 MEM/WB
//   muldiv_busy             the mul/div unit is in progress (FSM in BUSY)
//   muldiv_done             one-cycle pulse when HI/LO become valid
//   stall_cnt, flush_cnt    saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reads_hilo,
    input  logic             id_is_muldiv,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             branch_taken_ex,
    input  logic             muldiv_start_ex,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             muldiv_busy,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MD_CNT_W = $clog2(MULDIV_LAT + 1);
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_LAT - 1);
    localparam logic [MD_CNT_W-1:0] MD_ONE  = MD_CNT_W'(1);
    localparam logic [MD_CNT_W-1:0] MD_ZERO = '0;
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t             r_md_state;
    md_state_t             w_md_state_nxt;
    logic [MD_CNT_W-1:0]   r_md_cnt;
    logic [MD_CNT_W-1:0]   w_md_cnt_nxt;
    logic                  r_md_done;
    logic                  w_md_done_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic                  w_lu;
    logic                  w_md;
    logic                  w_stall;
    logic                  w_stall_inc;

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) ||
                   (id_uses_rt && (id_rt == ex_rd)));

    assign w_md    = muldiv_busy && (id_reads_hilo || id_is_muldiv);
    assign w_stall = w_lu || w_md;

    // A stall cycle squashed by a taken branch is not a stall cycle.
    assign w_stall_inc = w_stall && !branch_taken_ex;

    // ---------------------------------------------------------------------
    // Pipeline control, in priority order: reset, branch, stall, run.
    // ---------------------------------------------------------------------
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!reset_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Forwarding: the younger result (EX/MEM) wins over MEM/WB.
    // ---------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reset_n) begin
            fwd_a = fwd_sel(ex_rs);
            fwd_b = fwd_sel(ex_rt);
        end
    end

    // ---------------------------------------------------------------------
    // Mul/div FSM. md_cnt is loaded with LAT-1 on start and the FSM leaves
    // BUSY when it reads 1, so the done pulse lands exactly LAT cycles after
    // the start cycle. A start seen while BUSY is ignored.
    // ---------------------------------------------------------------------
    always_comb begin
        w_md_state_nxt = r_md_state;
        w_md_cnt_nxt   = r_md_cnt;
        w_md_done_nxt  = 1'b0;
        case (r_md_state)
            MD_IDLE: begin
                if (muldiv_start_ex) begin
                    w_md_state_nxt = MD_BUSY;
                    w_md_cnt_nxt   = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (r_md_cnt <= MD_ONE) begin
                    w_md_state_nxt = MD_IDLE;
                    w_md_cnt_nxt   = MD_ZERO;
                    w_md_done_nxt  = 1'b1;
                end else begin
                    w_md_cnt_nxt   = r_md_cnt - MD_ONE;
                end
            end
            default: begin
                w_md_state_nxt = MD_IDLE;
                w_md_cnt_nxt   = MD_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_md_state  <= MD_IDLE;
            r_md_cnt    <= MD_ZERO;
            r_md_done   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_md_state <= w_md_state_nxt;
            r_md_cnt   <= w_md_cnt_nxt;
            r_md_done  <= w_md_done_nxt;
            if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (branch_taken_ex && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign muldiv_busy = (r_md_state == MD_BUSY);
    assign muldiv_done = r_md_done && reset_n;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pipeline_hazard_ctrl.
// Inputs change 1 time unit after each rising edge; outputs are compared on
// the falling edge. The reference model tracks the mul/div window by cycle
// number (start cycle + LAT) and the counters as plain integers.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int LAT   = 4;
    localparam int CW    = 4;
    localparam int C_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          id_uses_rs, id_uses_rt, id_reads_hilo, id_is_muldiv;
    logic          ex_mem_read, mem_reg_write, wb_reg_write;
    logic          branch_taken_ex, muldiv_start_ex;
    logic          pc_write, ifid_write, ifid_flush, idex_flush;
    logic [1:0]    fwd_a, fwd_b;
    logic          muldiv_busy, muldiv_done;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // reference model state
    int cyc        = 0;
    bit md_active  = 1'b0;
    int md_start   = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reads_hilo(id_reads_hilo), .id_is_muldiv(id_is_muldiv),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .branch_taken_ex(branch_taken_ex), .muldiv_start_ex(muldiv_start_ex),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    // ---------------- model + compare process ----------------
    always @(negedge clk) begin
        bit busy_e, done_e, lu_e, md_e;
        bit pcw_e, ifw_e, iff_e, idf_e;
        logic [1:0] fa_e, fb_e;
        busy_e = md_active && (cyc > md_start) && (cyc < md_start + LAT);
        done_e = reset_n && md_active && (cyc == md_start + LAT);
        lu_e   = ex_mem_read && ex_rd != 0 &&
                 ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        md_e   = busy_e && (id_reads_hilo || id_is_muldiv);
        if (!reset_n) begin
            {pcw_e, ifw_e, iff_e, idf_e} = 4'b0011;
            fa_e = 2'b00; fb_e = 2'b00;
        end else begin
            if (branch_taken_ex)      {pcw_e, ifw_e, iff_e, idf_e} = 4'b1111;
            else if (lu_e || md_e)    {pcw_e, ifw_e, iff_e, idf_e} = 4'b0001;
            else                      {pcw_e, ifw_e, iff_e, idf_e} = 4'b1100;
            fa_e = m_fwd(ex_rs);
            fb_e = m_fwd(ex_rt);
        end
        if (chk_en) begin
            check("pc_write",    pc_write,    pcw_e);
            check("ifid_write",  ifid_write,  ifw_e);
            check("ifid_flush",  ifid_flush,  iff_e);
            check("idex_flush",  idex_flush,  idf_e);
            check("fwd_a",       fwd_a,       fa_e);
            check("fwd_b",       fwd_b,       fb_e);
            check("muldiv_busy", muldiv_busy, busy_e);
            check("muldiv_done", muldiv_done, done_e);
            check("stall_cnt",   stall_cnt,   m_stall);
            check("flush_cnt",   flush_cnt,   m_flush);
        end
        // state seen after the coming rising edge
        if (!reset_n) begin
            md_active = 1'b0;
            m_stall   = 0;
            m_flush   = 0;
        end else begin
            if (muldiv_start_ex && !busy_e) begin
                md_active = 1'b1;
                md_start  = cyc;
            end
            if (branch_taken_ex) m_flush = (m_flush == C_MAX) ? C_MAX : m_flush + 1;
            else if (lu_e || md_e) m_stall = (m_stall == C_MAX) ? C_MAX : m_stall + 1;
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        reset_n = 1'b1;
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_reads_hilo = 0; id_is_muldiv = 0;
        ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
        branch_taken_ex = 0; muldiv_start_ex = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        sample();
        check("rst_pc_write",   pc_write,   1'b0);
        check("rst_ifid_flush", ifid_flush, 1'b1);
        check("rst_idex_flush", idex_flush, 1'b1);
        check("rst_stall_cnt",  stall_cnt,  0);

        // T1: load-use on rs
        step(); ex_mem_read = 1; ex_rd = 19; id_uses_rs = 1; id_rs = 19;
        sample();
        check("t1_pc_write",   pc_write,   1'b0);
        check("t1_ifid_write", ifid_write, 1'b0);
        check("t1_idex_flush", idex_flush, 1'b1);
        step();
        sample();
        check("t1_stall_cnt",  stall_cnt,  1);
        check("t1_release",    pc_write,   1'b1);

        // T2: load to $zero never stalls
        step(); ex_mem_read = 1; ex_rd = 0; id_uses_rs = 1; id_rs = 0;
        sample();
        check("t2_pc_write",   pc_write,   1'b1);
        check("t2_idex_flush", idex_flush, 1'b0);

        // T3: forwarding priority
        step(); mem_reg_write = 1; mem_rd = 20; wb_reg_write = 1; wb_rd = 20; ex_rs = 20;
        sample();
        check("t3_fwd_mem", fwd_a, 2'b10);
        step(); wb_reg_write = 1; wb_rd = 20; ex_rs = 20;
        sample();
        check("t3_fwd_wb", fwd_a, 2'b01);

        // T4: mul/div window with mflo waiting in ID
        step(); muldiv_start_ex = 1;
        sample();
        check("t4_start_busy", muldiv_busy, 1'b0);
        for (int i = 1; i < LAT; i++) begin
            step(); id_reads_hilo = 1;
            sample();
            check("t4_busy",  muldiv_busy, 1'b1);
            check("t4_stall", pc_write,    1'b0);
        end
        step(); id_reads_hilo = 1;
        sample();
        check("t4_done",     muldiv_done, 1'b1);
        check("t4_idle",     muldiv_busy, 1'b0);
        check("t4_run",      pc_write,    1'b1);
        step();
        sample();
        check("t4_done_off", muldiv_done, 1'b0);
        check("t4_stall_cnt", stall_cnt,  4);

        // T5: branch overrides load-use
        step(); branch_taken_ex = 1; ex_mem_read = 1; ex_rd = 5; id_uses_rt = 1; id_rt = 5;
        sample();
        check("t5_pc_write",   pc_write,   1'b1);
        check("t5_ifid_flush", ifid_flush, 1'b1);
        check("t5_idex_flush", idex_flush, 1'b1);
        step();
        sample();
        check("t5_flush_cnt", flush_cnt, 1);
        check("t5_stall_cnt", stall_cnt, 4);

        // T6: reset aborts BUSY without a done pulse
        step(); muldiv_start_ex = 1;
        step();
        sample();
        check("t6_busy", muldiv_busy, 1'b1);
        step(); reset_n = 0;
        sample();
        check("t6_rst_pc_write", pc_write, 1'b0);
        step(); reset_n = 0;
        sample();
        check("t6_idle",      muldiv_busy, 1'b0);
        check("t6_stall_clr", stall_cnt,   0);
        check("t6_flush_clr", flush_cnt,   0);
        step();
        sample();
        check("t6_no_done", muldiv_done, 1'b0);

        // saturation of the stall counter
        for (int i = 0; i < C_MAX + 5; i++) begin
            step(); ex_mem_read = 1; ex_rd = 7; id_uses_rs = 1; id_rs = 7;
        end
        step();
        sample();
        check("sat_stall_cnt", stall_cnt, C_MAX);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            reset_n         = ($urandom_range(0, 99) != 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rs           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            mem_rd          = 5'($urandom_range(0, 3));
            wb_rd           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_reads_hilo   = ($urandom_range(0, 3) == 0);
            id_is_muldiv    = ($urandom_range(0, 5) == 0);
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            mem_reg_write   = 1'($urandom_range(0, 1));
            wb_reg_write    = 1'($urandom_range(0, 1));
            branch_taken_ex = ($urandom_range(0, 9) == 0);
            muldiv_start_ex = ($urandom_range(0, 5) == 0);
        end
        step();
        sample();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
